// File: rtl/out_display_unit_pkg.sv
// out_disp_pkg: shared constants for the OUT display unit.
// Holds the OUT selector codes, the digit count and the hex-to-7-segment table.
// No ports; imported by seg_decoder and out_display_unit.
package out_disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [3:0] OSEL_A   = 4'd0;
  localparam logic [3:0] OSEL_B   = 4'd1;
  localparam logic [3:0] OSEL_AB  = 4'd2;
  localparam logic [3:0] OSEL_CLR = 4'd3;

  typedef logic [3:0] nibble_t;

  // Active-high segments, bit0 = a .. bit6 = g. Entry [15] is listed first.
  localparam logic [15:0][6:0] HEX7 = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,  // F..8
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F   // 7..0
  };

endpackage

// File: rtl/out_display_unit_if.sv
// out_display_unit_if: processor OUT-instruction bus into the display unit.
// Signals: outval1/outval2 (16b data), outsel (4b selector), outdisplay (1-cycle strobe),
//          halting (level). master = processor side, slave = display side. No backpressure.
interface out_display_unit_if;
  logic [15:0] outval1;
  logic [15:0] outval2;
  logic [3:0]  outsel;
  logic        outdisplay;
  logic        halting;

  modport master (output outval1, outval2, outsel, outdisplay, halting);
  modport slave  (input  outval1, outval2, outsel, outdisplay, halting);
endinterface

// File: rtl/out_display_unit_seg_decoder.sv
// seg_decoder: combinational hex nibble to active-low 7-segment pattern.
// Ports: nib_i (4b hex digit) -> seg_n_o (7b, g..a, active-low). Zero latency.
// No handshake; pure function of the input.
module seg_decoder
  import out_disp_pkg::*;
(
  input  nibble_t    nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = ~HEX7[nib_i];

endmodule

// File: rtl/out_display_unit.sv
// out_display_unit: captures OUT values into two 16-bit banks and scans them in hex
// onto an 8-digit multiplexed active-low 7-segment display (digits 7..4 = bank A, 3..0 = bank B).
// Ports: clock, reset (sync, active-high), proc (OUT bus, slave), seg_n/an_n (registered pins),
// bank_a/bank_b, out_count (accepted OUTs, wraps), bad_sel (sticky bad selector).
// Banks update one cycle after the strobe; pins lag the scan index by one cycle. Never stalls.
// Optional build macro HALT_BLINK_EN: while halting, blank the display every BLINK_FRAMES scans.
module out_display_unit
  import out_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  out_display_unit_if.slave    proc,
  output logic [6:0]           seg_n,
  output logic [7:0]           an_n,
  output logic [15:0]          bank_a,
  output logic [15:0]          bank_b,
  output logic [7:0]           out_count,
  output logic                 bad_sel
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [15:0] bank_a_q, bank_a_d, bank_b_q, bank_b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_dec;
  logic        presc_wrap;
  logic        blank;
  logic [31:0] disp_word;
  nibble_t     nib;

  // Capture and event counting.
  always_comb begin
    bank_a_d = bank_a_q;
    bank_b_d = bank_b_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    if (proc.outdisplay) begin
      case (proc.outsel)
        OSEL_A:   begin bank_a_d = proc.outval1; cnt_d = cnt_q + 8'd1; end
        OSEL_B:   begin bank_b_d = proc.outval1; cnt_d = cnt_q + 8'd1; end
        OSEL_AB:  begin
          bank_a_d = proc.outval1;
          bank_b_d = proc.outval2;
          cnt_d    = cnt_q + 8'd1;
        end
        OSEL_CLR: begin bank_a_d = '0; bank_b_d = '0; cnt_d = cnt_q + 8'd1; end
        default:  bad_d = 1'b1;
      endcase
    end
  end

  // Scan: the index steps downward (0 -> 7 -> 6 ...) each time the prescaler wraps.
  always_comb begin
    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d      = presc_wrap ? idx_q - 3'd1 : idx_q;
    disp_word  = {bank_a_q, bank_b_q};
    nib        = disp_word[{idx_q, 2'b00} +: 4];
    an_d       = blank ? 8'hFF : ~(8'h01 << idx_q);
  end

  seg_decoder u_seg_decoder (
    .nib_i   (nib),
    .seg_n_o (seg_dec)
  );

`ifdef HALT_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;

  // A frame completes when the index wraps from digit 0 back to digit 7.
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (!proc.halting) begin
      frame_d = '0;
      phase_d = 1'b0;
    end else if (presc_wrap && (idx_q == 3'd0)) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign blank = phase_q;
`else
  logic unused_halting;
  assign unused_halting = proc.halting;
  assign blank          = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_a_q <= '0;
      bank_b_q <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
    end else begin
      bank_a_q <= bank_a_d;
      bank_b_q <= bank_b_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_dec;
    end
  end

  assign seg_n     = seg_q;
  assign an_n      = an_q;
  assign bank_a    = bank_a_q;
  assign bank_b    = bank_b_q;
  assign out_count = cnt_q;
  assign bad_sel   = bad_q;

endmodule
